// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the boot-time instruction memory loader.
package imem_loader_pkg;

   localparam int unsigned COUNT_W = 32;
   localparam int unsigned CSUM_W  = 8;

   typedef enum logic [2:0] {
      ST_LEN   = 3'd0,
      ST_DATA  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

endpackage

// File: rtl/imem_loader_reg_en.sv
// Generic register with load enable and asynchronous active-high reset.
module reg_en #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word/word_valid
// already include the byte being accepted this cycle.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               byte_en,
   input  logic [7:0]         byte_in,
   output logic [COUNT_W-1:0] word,
   output logic               word_valid
);

   logic [1:0]         byte_cnt;
   logic [COUNT_W-1:0] shift_q;

   // Shifting in from the top lands byte k at bits [8k+7:8k] after four bytes.
   always_comb begin
      word       = {byte_in, shift_q[COUNT_W-1:8]};
      word_valid = byte_en && (byte_cnt == 2'd3);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         shift_q  <= '0;
      end else if (clr) begin
         byte_cnt <= '0;
         shift_q  <= '0;
      end else if (byte_en) begin
         byte_cnt <= byte_cnt + 2'd1;
         shift_q  <= word;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes instruction memory,
// verifies an XOR checksum and releases the core only on a clean load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic        load_req,
   output logic        imem_we,
   output logic [31:0] imem_waddr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst,
   output logic        cpu_en,
   output logic        done,
   output logic        error
);

   state_t             state;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] word_idx;
   logic [CSUM_W-1:0]  csum;
   logic [COUNT_W-1:0] asm_word;
   logic               word_valid;
   logic               xfer;
   logic               load_clr;
   logic               asm_en;
   logic               count_en;
   logic [COUNT_W-1:0] count_d;

   always_comb begin
      xfer     = rx_valid && rx_ready;
      load_clr = load_req && ((state == ST_DONE) || (state == ST_ERROR));
      asm_en   = xfer && ((state == ST_LEN) || (state == ST_DATA));
      count_en = load_clr || ((state == ST_LEN) && word_valid);
      count_d  = load_clr ? '0 : asm_word;
   end

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr        (load_clr),
      .byte_en    (asm_en),
      .byte_in    (rx_data),
      .word       (asm_word),
      .word_valid (word_valid)
   );

   reg_en #(.W(COUNT_W)) u_count (
      .clk (clk),
      .rst (rst),
      .en  (count_en),
      .d   (count_d),
      .q   (count_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_LEN;
         rx_ready   <= 1'b1;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         cpu_rst    <= 1'b1;
         cpu_en     <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_idx   <= '0;
         csum       <= '0;
      end else begin
         imem_we <= 1'b0;
         unique case (state)
            ST_LEN: begin
               if (xfer) begin
                  csum <= csum ^ rx_data;
                  if (word_valid) begin
                     if (asm_word > COUNT_W'(DEPTH_WORDS)) begin
                        state    <= ST_ERROR;
                        rx_ready <= 1'b0;
                        error    <= 1'b1;
                     end else if (asm_word == '0) begin
                        state <= ST_CHECK;
                     end else begin
                        state <= ST_DATA;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  csum <= csum ^ rx_data;
                  if (word_valid) begin
                     imem_we    <= 1'b1;
                     imem_waddr <= {word_idx[COUNT_W-3:0], 2'b00};
                     imem_wdata <= asm_word;
                     word_idx   <= word_idx + COUNT_W'(1);
                     if (word_idx + COUNT_W'(1) == count_q) state <= ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               if (xfer) begin
                  rx_ready <= 1'b0;
                  if (rx_data == csum) begin
                     state   <= ST_DONE;
                     done    <= 1'b1;
                     cpu_rst <= 1'b0;
                     cpu_en  <= 1'b1;
                  end else begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
            end
            ST_DONE, ST_ERROR: begin
               if (load_req) begin
                  state    <= ST_LEN;
                  rx_ready <= 1'b1;
                  cpu_rst  <= 1'b1;
                  cpu_en   <= 1'b0;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  word_idx <= '0;
                  csum     <= '0;
               end
            end
            default: begin
               state    <= ST_ERROR;
               rx_ready <= 1'b0;
               cpu_rst  <= 1'b1;
               cpu_en   <= 1'b0;
               done     <= 1'b0;
               error    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready;
   logic        load_req = 1'b0;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        cpu_en;
   logic        done;
   logic        error;

   int total = 0;
   int bad = 0;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic [7:0]  fb[$];

   always #5 clk = ~clk;

   imem_loader #(.DEPTH_WORDS(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .load_req   (load_req),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .cpu_en     (cpu_en),
      .done       (done),
      .error      (error)
   );

   always @(negedge clk) begin
      if (!rst && imem_we) begin
         wa_q.push_back(imem_waddr);
         wd_q.push_back(imem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one byte and returns #1 after the edge that accepts it.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_fb(input int first, input int last, input int gap_max);
      for (int i = first; i <= last; i++) begin
         send_byte(fb[i]);
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
         #0;
      end
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
      chk({tag, "_we"},       {31'd0, imem_we},  32'd0);
      chk({tag, "_waddr"},    imem_waddr,        32'd0);
      chk({tag, "_wdata"},    imem_wdata,        32'd0);
      chk({tag, "_cpu_rst"},  {31'd0, cpu_rst},  32'd1);
      chk({tag, "_cpu_en"},   {31'd0, cpu_en},   32'd0);
      chk({tag, "_done"},     {31'd0, done},     32'd0);
      chk({tag, "_error"},    {31'd0, error},    32'd0);
   endtask

   task automatic load_frame_a(input logic [7:0] csum_byte);
      fb = '{8'h02, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h50, 8'h00,
             8'h13, 8'h01, 8'h10, 8'h00, csum_byte};
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Frame A, good checksum: 0x02 ^ 0x93 ^ 0x50 ^ 0x13 ^ 0x01 ^ 0x10 = 0xC3
      clear_log();
      load_frame_a(8'hC3);
      send_fb(0, 11, 0);
      chk("a_last_we",    {31'd0, imem_we}, 32'd1);
      chk("a_last_waddr", imem_waddr,       32'h4);
      chk("a_check_rdy",  {31'd0, rx_ready}, 32'd1);
      chk("a_check_done", {31'd0, done},     32'd0);
      send_fb(12, 12, 0);
      chk("a_done",    {31'd0, done},     32'd1);
      chk("a_cpu_rst", {31'd0, cpu_rst},  32'd0);
      chk("a_cpu_en",  {31'd0, cpu_en},   32'd1);
      chk("a_rdy0",    {31'd0, rx_ready}, 32'd0);
      chk("a_we_idle", {31'd0, imem_we},  32'd0);
      chk("a_nwr", wa_q.size(), 32'd2);
      if (wa_q.size() == 2) begin
         chk("a_w0_addr", wa_q[0], 32'h0);
         chk("a_w0_data", wd_q[0], 32'h00500093);
         chk("a_w1_addr", wa_q[1], 32'h4);
         chk("a_w1_data", wd_q[1], 32'h00100113);
      end

      // Same frame, checksum flipped
      pulse_load();
      chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("reload_rdy",     {31'd0, rx_ready}, 32'd1);
      chk("reload_done",    {31'd0, done},     32'd0);
      clear_log();
      load_frame_a(8'hC2);
      send_fb(0, 12, 0);
      chk("bad_error",   {31'd0, error},   32'd1);
      chk("bad_done",    {31'd0, done},    32'd0);
      chk("bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("bad_cpu_en",  {31'd0, cpu_en},  32'd0);
      chk("bad_nwr", wa_q.size(), 32'd2);

      // Oversize count 257
      pulse_load();
      clear_log();
      fb = '{8'h01, 8'h01, 8'h00, 8'h00};
      send_fb(0, 3, 0);
      chk("big_error", {31'd0, error},    32'd1);
      chk("big_rdy",   {31'd0, rx_ready}, 32'd0);
      chk("big_done",  {31'd0, done},     32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("big_nwr", wa_q.size(), 32'd0);

      // Empty frame, checksum 0x00 then 0x5A
      pulse_load();
      clear_log();
      fb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_fb(0, 3, 0);
      chk("n0_check_rdy", {31'd0, rx_ready}, 32'd1);
      send_fb(4, 4, 0);
      chk("n0_done", {31'd0, done}, 32'd1);
      chk("n0_nwr", wa_q.size(), 32'd0);
      pulse_load();
      fb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
      send_fb(0, 4, 0);
      chk("n0bad_error", {31'd0, error}, 32'd1);
      chk("n0bad_done",  {31'd0, done},  32'd0);

      // Gapped stream, reset after 6 payload bytes, then a fresh frame
      pulse_load();
      load_frame_a(8'hC3);
      send_fb(0, 9, 2);
      rst = 1'b1;
      #2;
      chk_reset_vals("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      clear_log();
      send_fb(0, 12, 2);
      chk("fresh_done", {31'd0, done}, 32'd1);
      chk("fresh_nwr", wa_q.size(), 32'd2);
      if (wa_q.size() == 2) begin
         chk("fresh_w0_addr", wa_q[0], 32'h0);
         chk("fresh_w0_data", wd_q[0], 32'h00500093);
         chk("fresh_w1_addr", wa_q[1], 32'h4);
         chk("fresh_w1_data", wd_q[1], 32'h00100113);
      end

      // Reload with one word: 0x01 ^ 0xEF ^ 0xBE ^ 0xAD ^ 0xDE = 0x23
      pulse_load();
      chk("dead_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("dead_cpu_en",  {31'd0, cpu_en},  32'd0);
      clear_log();
      fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
      send_fb(0, 8, 0);
      chk("dead_done", {31'd0, done},    32'd1);
      chk("dead_cpu_rst_lo", {31'd0, cpu_rst}, 32'd0);
      chk("dead_nwr", wa_q.size(), 32'd1);
      if (wa_q.size() == 1) begin
         chk("dead_addr", wa_q[0], 32'h0);
         chk("dead_data", wd_q[0], 32'hDEADBEEF);
      end

      // load_req outside DONE/ERROR is ignored
      pulse_load();
      fb = '{8'h00};
      send_fb(0, 0, 0);
      pulse_load();
      chk("ign_rdy",  {31'd0, rx_ready}, 32'd1);
      chk("ign_done", {31'd0, done},     32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory, the write-side counterpart to the fetch stage's read-only instruction port. It accepts a framed little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. It issues one memory write per word and checks an XOR checksum. The core is held in reset with PC update disabled until a frame loads cleanly.

## Interface

- DEPTH_WORDS, 256: instruction memory capacity in words; frames with a larger word count are rejected.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs when rx_valid & rx_ready.
- load_req  in  1  single-cycle request to start a new frame; honoured only in DONE or ERROR.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_waddr  out  32  byte address of the write; bits [1:0] always 0.
- imem_wdata  out  32  assembled instruction word.
- cpu_rst  out  1  core reset hold; high in every state except DONE.
- cpu_en  out  1  PC register enable; high only in DONE.
- done  out  1  frame loaded and checksum good.
- error  out  1  frame rejected.

## Operation

- Frame format: 4-byte word count N (LSB first), then N×4 payload bytes (each word LSB first), then 1 checksum byte.
- The checksum byte must equal the XOR of all preceding frame bytes: the 4 count bytes plus all payload bytes.
- States: LEN, DATA, CHECK, DONE, ERROR.
- LEN: rx_ready=1. Shift bytes into the count register.
  - On the 4th byte, if N > DEPTH_WORDS, go to ERROR.
  - Else if N == 0, go to CHECK.
  - Else go to DATA.
- DATA: rx_ready=1. A 2-bit byte counter places byte k at word bits [8k+7:8k].
  - On the 4th byte, register imem_wdata = assembled word and imem_waddr = word_idx×4, and pulse imem_we.
  - word_idx increments on each write, wrapping is impossible since word_idx ≤ N ≤ DEPTH_WORDS.
  - When word_idx reaches N, go to CHECK.
- CHECK: rx_ready=1. Compare the accepted byte with the running XOR.
  - Equal: go to DONE.
  - Not equal: go to ERROR.
- DONE: rx_ready=0, done=1, cpu_rst=0, cpu_en=1.
- ERROR: rx_ready=0, error=1, cpu_rst=1, cpu_en=0.
- load_req in DONE or ERROR moves to LEN and clears the count, word_idx, byte counter, XOR and flags. cpu_rst reasserts the same cycle that state becomes LEN.
- load_req in LEN, DATA or CHECK is ignored. Bytes offered in DONE or ERROR are not accepted.
- Reset values: state=LEN, rx_ready=1, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_rst=1, cpu_en=0, done=0, error=0. All counters and the XOR accumulator are 0.
- Reset mid-frame discards all partial progress. Memory contents already written are left as-is.

## Timing

- rx_ready is a function of state only; the loader never stalls inside LEN, DATA or CHECK. Back-to-back bytes every cycle are sustained.
- imem_we is registered and asserts the cycle after the 4th byte of a word is accepted, for exactly 1 cycle. imem_waddr and imem_wdata are valid in that same cycle.
- The last word's imem_we pulse coincides with the first CHECK cycle.
- done, cpu_en and the deassertion of cpu_rst appear the cycle after the checksum byte is accepted. error asserts at the same point on a mismatch.
- Oversize count: error asserts the cycle after the 4th count byte, and no write is issued.
- Memory write latency is one cycle, so an instruction written at address A is readable by fetch before cpu_rst deasserts.

## Structure

- Shared package/header holds:
  - state encodings LEN/DATA/CHECK/DONE/ERROR (3-bit);
  - the frame count field width (32);
  - the checksum width (8).
- Sub-module word_assembler contains the 2-bit byte counter, the 32-bit shift register and a word_valid pulse. The top level contains the FSM, word_idx, XOR accumulator and output registers.
- The existing 32-bit register with enable is reused for the count register.

## Test plan

- N=2, words 0x00500093 and 0x00100113, correct checksum.
  - Exactly 2 imem_we pulses: (0x0, 0x00500093) then (0x4, 0x00100113).
  - Then done=1, cpu_rst=0, cpu_en=1.
- Same frame with the checksum byte flipped (XOR 0x01) -> both writes occur, then error=1, cpu_rst stays 1, done=0.
- N=DEPTH_WORDS+1 (257) -> error the cycle after the 4th byte, zero writes, rx_ready=0.
- N=0 with checksum 0x00 -> no writes, done=1. With checksum 0x5A -> error=1.
- Random rx_valid gaps plus rst pulsed after 6 payload bytes.
  - All outputs return to reset values.
  - A fresh full frame then loads correctly from address 0.
- After DONE, pulse load_req and send a 1-word frame 0xDEADBEEF -> cpu_rst reasserts immediately, write (0x0, 0xDEADBEEF), done again.
